sec_disp_scan: RTL and testbench
================================

Name: sec_disp_scan

Overview:
- Display stage directly downstream of the seconds counter in the digital clock.
- Takes the 6-bit binary seconds value (0..59) from the slow seconds domain and synchronises it into the fast system clock.
- Converts it to two BCD digits with an iterative double-dabble FSM.
- Drives a time-multiplexed, active-low, two-digit 7-segment display.

Parameters:
- SCAN_DIV, 50000, inclk cycles each digit is enabled before the scan moves to the other digit (minimum 2).
- SYNC_STAGES, 2, flip-flop stages in the sec_in synchroniser (minimum 2).

Ports:
- rst  input  1  asynchronous active-low reset.
- inclk  input  1  system clock; the fast clock, not the 1 Hz seconds clock.
- sec_in  input  6  binary seconds from the seconds counter; asynchronous to inclk.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an_n  output  2  digit enables, active-low; bit0 = units, bit1 = tens.
- conv_busy  output  1  high while the BCD conversion FSM is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - seg_n=7'h7F, an_n=2'b11, conv_busy=0.
  - Synchroniser, capture, digit and scan registers are cleared; FSM goes to IDLE.
  - A conversion request is forced pending, so the first post-reset conversion always runs.
- Clock/reset: decided as reset rst, asynchronous, active-low; clock inclk. All registers are on posedge inclk / negedge rst.
- Synchroniser: sec_in passes through SYNC_STAGES flops to give sync_q.
- Skew filter: sec_cap loads sync_q only when sync_q equals its own one-cycle-delayed copy. A multi-bit transition therefore never captures a mixed value.
- Request: raised when sec_cap differs from last_conv, or when the post-reset force is pending.
- FSM states:
  - IDLE: on a request, load shift reg {8'b0, sec_cap} (14 bits), set last_conv=sec_cap, count=0, go to SHIFT.
  - SHIFT: each cycle, add 3 to any BCD nibble >=5, then shift left 1. Stay 6 cycles (count 0..5), then go to DONE.
  - DONE: one cycle. Transfer the tens/units nibbles into the display registers atomically, both on the same edge. Return to IDLE.
- conv_busy is high in SHIFT and DONE.
- Latency: the display registers update exactly 8 cycles after the request is first seen in IDLE.
- Value change mid-conversion: there is no abort. last_conv mismatch re-requests in IDLE, so the final stable value is always displayed.
- Out of range (sec_cap 60..63): conversion still runs. DONE loads the dash code (segment g only, 7'h3F active-low) into both digits.
- Scan counter:
  - Counts 0..SCAN_DIV-1, then wraps to 0 and toggles the digit select. The counter runs continuously, independent of the FSM.
  - digit select 0 gives an_n=2'b10 with the units pattern; select 1 gives an_n=2'b01 with the tens pattern.
  - seg_n and an_n are registered and change on the same edge, so there is no ghosting.
  - First enable after reset: the units digit, on the cycle after the first wrap (cycle SCAN_DIV); an_n stays 2'b11 until then.
- Zero display: no leading-zero blanking; 0 seconds displays "00".
- Segment codes (active-low gfedcba):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
  - Dash = 3F. BCD >9 is impossible; if it occurs, decode to blank 7F.

Decomposition:
- Package clk_disp_pkg holds:
  - FSM state typedef {IDLE, SHIFT, DONE};
  - SEG_0..SEG_9, SEG_DASH, SEG_BLANK constants;
  - BCD_ITER=6 constant;
  - SEC_MAX=59 constant.
- One combinational sub-module, seg7_dec (4-bit BCD in, 7-bit active-low pattern out, blank for >9). It is instantiated twice, once per digit.
- Synchroniser, FSM and scan counter stay in the top module.

Test Plan:
- Reset: hold rst low, then release with sec_in=0 -> seg_n=7F and an_n=11 during reset. Forced conversion runs, conv_busy is high for 7 cycles, and the display shows "00" (both digits 40).
- Static conversion with SCAN_DIV=4: sec_in=37 -> units phase gives an_n=10 with seg_n=78 ('7'); tens phase gives an_n=01 with seg_n=30 ('3'). Alternation every 4 cycles.
- Boundary: sec_in 59 -> 0 wrap -> "59" (12,10), then "00". No intermediate digit pair is ever displayed.
- Mid-conversion change: sec_in=12, then sec_in=45 driven 3 cycles into SHIFT -> "12" displays first, then a second conversion runs and the final display is "45". "14"/"42" never appear.
- Skew: sec_in moves 31 -> 32 with one-cycle-staggered bit changes (a transient 30 for exactly one synchroniser cycle) -> sec_cap never equals the transient, and the display goes "31" to "32" only.
- Out of range and reset mid-operation: sec_in=62 -> both digits 3F. Asserting rst during SHIFT immediately gives seg_n=7F, an_n=11, conv_busy=0.

Source files
------------

// File: rtl/clk_disp_pkg.sv
// Shared definitions for the seconds display stage: FSM encoding, segment codes
// and the double-dabble nibble adjust.
package clk_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int BCD_ITER = 6;
  localparam int SEC_MAX  = 59;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    dd_adj = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/sec_disp_scan_seg7_dec.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes show blank.
module seg7_dec
  import clk_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_n_o = SEG_0;
      4'd1: seg_n_o = SEG_1;
      4'd2: seg_n_o = SEG_2;
      4'd3: seg_n_o = SEG_3;
      4'd4: seg_n_o = SEG_4;
      4'd5: seg_n_o = SEG_5;
      4'd6: seg_n_o = SEG_6;
      4'd7: seg_n_o = SEG_7;
      4'd8: seg_n_o = SEG_8;
      4'd9: seg_n_o = SEG_9;
      default: seg_n_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sec_disp_scan.sv
// Seconds display: synchronise binary seconds, convert to BCD with a
// double-dabble FSM, and scan two active-low 7-segment digits.
module sec_disp_scan
  import clk_disp_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       rst,
  input  logic       inclk,
  input  logic [5:0] sec_in,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       conv_busy
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [5:0]    sync_q [SYNC_STAGES];
  logic [5:0]    sync_dly_q;
  logic [5:0]    sec_cap_q;
  logic [5:0]    last_conv_q, last_conv_d;
  logic          force_q, force_d;
  state_t        state_q, state_d;
  logic [13:0]   shift_q, shift_d;
  logic [13:0]   adj_w;
  logic [2:0]    count_q, count_d;
  logic [3:0]    tens_q, tens_d, units_q, units_d;
  logic          dash_q, dash_d;
  logic          req_w;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d, en_q, en_d, wrap_w;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic [6:0]    units_seg_w, tens_seg_w, units_pat_w, tens_pat_w;

  // A new value is accepted only after it has been identical for two
  // consecutive cycles, so staggered bit changes never produce a mixed capture.
  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_dly_q <= '0;
      sec_cap_q  <= '0;
    end else begin
      sync_q[0] <= sec_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_dly_q <= sync_q[SYNC_STAGES-1];
      if (sync_q[SYNC_STAGES-1] == sync_dly_q) sec_cap_q <= sync_dly_q;
    end
  end

  assign req_w     = (sec_cap_q != last_conv_q) || force_q;
  assign conv_busy = (state_q != IDLE);
  assign adj_w     = {dd_adj(shift_q[13:10]), dd_adj(shift_q[9:6]), shift_q[5:0]};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    last_conv_d = last_conv_q;
    force_d     = force_q;
    tens_d      = tens_q;
    units_d     = units_q;
    dash_d      = dash_q;
    case (state_q)
      IDLE: begin
        if (req_w) begin
          shift_d     = {8'b0, sec_cap_q};
          last_conv_d = sec_cap_q;
          count_d     = '0;
          force_d     = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = {adj_w[12:0], 1'b0};
        count_d = count_q + 3'd1;
        if (count_q == 3'(BCD_ITER - 1)) state_d = DONE;
      end
      DONE: begin
        // Both digits and the dash flag move together so no mixed pair shows
        tens_d  = shift_q[13:10];
        units_d = shift_q[9:6];
        dash_d  = (last_conv_q > 6'(SEC_MAX));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      last_conv_q <= '0;
      force_q     <= 1'b1;
      tens_q      <= '0;
      units_q     <= '0;
      dash_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      last_conv_q <= last_conv_d;
      force_q     <= force_d;
      tens_q      <= tens_d;
      units_q     <= units_d;
      dash_q      <= dash_d;
    end
  end

  seg7_dec u_dec_units (.bcd_i(units_q), .seg_n_o(units_seg_w));
  seg7_dec u_dec_tens  (.bcd_i(tens_q),  .seg_n_o(tens_seg_w));

  assign units_pat_w = dash_q ? SEG_DASH : units_seg_w;
  assign tens_pat_w  = dash_q ? SEG_DASH : tens_seg_w;

  // The first wrap only enables the display (units first); later wraps toggle.
  assign wrap_w = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = wrap_w ? '0 : cnt_q + 1'b1;
    en_d  = en_q | wrap_w;
    sel_d = (wrap_w && en_q) ? ~sel_q : sel_q;
    seg_d = SEG_BLANK;
    an_d  = 2'b11;
    if (en_d) begin
      seg_d = sel_d ? tens_pat_w : units_pat_w;
      an_d  = sel_d ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sel_q <= 1'b0;
      en_q  <= 1'b0;
      seg_q <= SEG_BLANK;
      an_q  <= 2'b11;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      en_q  <= en_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;

endmodule

// File: tb/tb_sec_disp_scan.sv
// Directed bench for sec_disp_scan with a short scan period: table of static
// values plus sequences for reset, wrap, mid-conversion change, skew and reset.
module tb_sec_disp_scan;

  localparam int N = 4;

  logic       rst;
  logic       inclk;
  logic [5:0] sec_in;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       conv_busy;

  int total;
  int bad;

  sec_disp_scan #(.SCAN_DIV(N), .SYNC_STAGES(2)) dut (
    .rst       (rst),
    .inclk     (inclk),
    .sec_in    (sec_in),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .conv_busy (conv_busy)
  );

  // clock/reset
  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  typedef struct {
    logic [5:0] sec;
    logic [6:0] u;
    logic [6:0] t;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Collect one full scan period; unseen digits stay X and fail their check.
  task automatic sample_digits(output logic [6:0] u, output logic [6:0] t);
    u = 'x;
    t = 'x;
    repeat (2 * N) begin
      @(negedge inclk);
      if (an_n == 2'b10) u = seg_n;
      else if (an_n == 2'b01) t = seg_n;
    end
  endtask

  task automatic settle_and_check(input string name, input logic [5:0] s,
                                  input logic [6:0] eu, input logic [6:0] et);
    logic [6:0] u, t;
    sec_in = s;
    repeat (30) @(negedge inclk);
    sample_digits(u, t);
    chk({name, "_units"}, {25'd0, u}, {25'd0, eu});
    chk({name, "_tens"},  {25'd0, t}, {25'd0, et});
  endtask

  // Every displayed digit must be one of three allowed patterns per position.
  task automatic watch(input int n, input logic [20:0] au, input logic [20:0] at,
                       input logic [6:0] want_u, output int viol, output bit saw);
    viol = 0;
    saw  = 1'b0;
    repeat (n) begin
      @(negedge inclk);
      if (an_n == 2'b10) begin
        if (seg_n != au[6:0] && seg_n != au[13:7] && seg_n != au[20:14]) viol++;
        if (seg_n == want_u) saw = 1'b1;
      end else if (an_n == 2'b01) begin
        if (seg_n != at[6:0] && seg_n != at[13:7] && seg_n != at[20:14]) viol++;
      end else begin
        viol++;
      end
    end
  endtask

  task automatic wait_busy(input string name);
    int k;
    k = 0;
    while (!conv_busy && k < 20) begin
      @(negedge inclk);
      k++;
    end
    chk(name, {31'd0, conv_busy}, 32'd1);
  endtask

  initial begin
    int         busy_cnt;
    int         viol;
    bit         saw;
    logic [6:0] u, t;

    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    sec_in = 6'd0;

    vecs[0] = '{6'd0,  7'h40, 7'h40};
    vecs[1] = '{6'd37, 7'h78, 7'h30};
    vecs[2] = '{6'd59, 7'h10, 7'h12};
    vecs[3] = '{6'd9,  7'h10, 7'h40};
    vecs[4] = '{6'd10, 7'h40, 7'h79};
    vecs[5] = '{6'd45, 7'h12, 7'h19};
    vecs[6] = '{6'd60, 7'h3F, 7'h3F};
    vecs[7] = '{6'd26, 7'h02, 7'h24};
    vecs[8] = '{6'd63, 7'h3F, 7'h3F};
    vecs[9] = '{6'd48, 7'h00, 7'h19};

    // Reset values and the forced first conversion
    repeat (3) @(negedge inclk);
    chk("rst_seg", {25'd0, seg_n}, 32'h7F);
    chk("rst_an", {30'd0, an_n}, 32'h3);
    chk("rst_busy", {31'd0, conv_busy}, 32'd0);
    rst = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge inclk);
      if (conv_busy) busy_cnt++;
      if (k == N - 1)     chk("an_before_first_wrap", {30'd0, an_n}, 32'h3);
      if (k == N)         chk("an_first_units", {30'd0, an_n}, 32'h2);
      if (k == 2 * N - 1) chk("an_units_hold", {30'd0, an_n}, 32'h2);
      if (k == 2 * N)     chk("an_first_tens", {30'd0, an_n}, 32'h1);
    end
    chk("forced_busy_cycles", busy_cnt, 32'd7);
    sample_digits(u, t);
    chk("post_rst_units", {25'd0, u}, 32'h40);
    chk("post_rst_tens", {25'd0, t}, 32'h40);

    // Static values
    for (int i = 0; i < 10; i++)
      settle_and_check($sformatf("vec%0d", i), vecs[i].sec, vecs[i].u, vecs[i].t);

    // 59 -> 0 wrap: only '59' and '00' digits may appear
    settle_and_check("pre_wrap", 6'd59, 7'h10, 7'h12);
    sec_in = 6'd0;
    watch(40, {7'h10, 7'h40, 7'h40}, {7'h12, 7'h40, 7'h40}, 7'h40, viol, saw);
    chk("wrap_no_mixed", viol, 32'd0);
    chk("wrap_reaches_00", {31'd0, saw}, 32'd1);

    // Change 12 -> 45 three cycles into the first conversion
    @(negedge inclk);
    sec_in = 6'd12;
    wait_busy("mid_busy_wait");
    repeat (3) @(negedge inclk);
    sec_in = 6'd45;
    watch(50, {7'h40, 7'h24, 7'h12}, {7'h40, 7'h79, 7'h19}, 7'h24, viol, saw);
    chk("mid_no_mixed", viol, 32'd0);
    chk("mid_shows_12_first", {31'd0, saw}, 32'd1);
    sample_digits(u, t);
    chk("mid_final_units", {25'd0, u}, 32'h12);
    chk("mid_final_tens", {25'd0, t}, 32'h19);

    // Skewed 31 -> 32 with a one-cycle transient 30
    settle_and_check("pre_skew", 6'd31, 7'h79, 7'h30);
    sec_in = 6'd30;
    @(negedge inclk);
    sec_in = 6'd32;
    watch(40, {7'h79, 7'h24, 7'h24}, {7'h30, 7'h30, 7'h30}, 7'h24, viol, saw);
    chk("skew_no_transient", viol, 32'd0);
    chk("skew_reaches_32", {31'd0, saw}, 32'd1);

    // Out of range, then reset during SHIFT
    settle_and_check("oor62", 6'd62, 7'h3F, 7'h3F);
    sec_in = 6'd10;
    wait_busy("rst_mid_busy_wait");
    repeat (2) @(negedge inclk);
    rst = 1'b0;
    #1;
    chk("mid_rst_seg", {25'd0, seg_n}, 32'h7F);
    chk("mid_rst_an", {30'd0, an_n}, 32'h3);
    chk("mid_rst_busy", {31'd0, conv_busy}, 32'd0);
    repeat (2) @(negedge inclk);
    rst = 1'b1;
    settle_and_check("after_mid_rst", 6'd10, 7'h40, 7'h79);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
